// File: rtl/ps2_byte_receiver.sv
// PS/2 keyboard byte receiver: synchronizes and deglitches the raw PS/2
// clock, samples data on filtered falling edges, checks the 11-bit frame and
// emits each good byte with a one-cycle strobe. Bad or stalled frames are
// dropped and reported with a one-cycle error pulse.
module ps2_byte_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] last_data_received,
    output logic       received_data_en,
    output logic       parity_error,
    output logic       frame_error
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state, state_n;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall_tick;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          par_bit, par_n;
    logic          data_en_n, perr_n, ferr_n;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Adopt a new clock level only after it has been stable FILTER_LEN cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall_tick = clk_filt_d & ~clk_filt;

    // A stalled frame is abandoned; a coincident fall_tick keeps it alive.
    assign timeout = (state != S_IDLE) && !fall_tick &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inter-edge watchdog: cleared by edges and while idle, saturating.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if (fall_tick || state_n == S_IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame sequencing and end-of-frame verdict.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        par_n     = par_bit;
        data_en_n = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_tick && !dat_s2) begin
                    state_n   = S_DATA;
                    bit_cnt_n = 3'd0;
                    shreg_n   = 8'h00;
                end
            end
            S_DATA: begin
                if (fall_tick) begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall_tick) begin
                    par_n   = dat_s2;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_tick) begin
                    state_n = S_IDLE;
                    if (!dat_s2)                 ferr_n    = 1'b1;
                    else if (^{shreg, par_bit})  data_en_n = 1'b1;
                    else                         perr_n    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (timeout) begin
            state_n   = S_IDLE;
            data_en_n = 1'b0;
            perr_n    = 1'b0;
            ferr_n    = 1'b1;
        end
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state              <= S_IDLE;
            shreg              <= 8'h00;
            bit_cnt            <= 3'd0;
            par_bit            <= 1'b0;
            last_data_received <= 8'h00;
            received_data_en   <= 1'b0;
            parity_error       <= 1'b0;
            frame_error        <= 1'b0;
        end else begin
            state            <= state_n;
            shreg            <= shreg_n;
            bit_cnt          <= bit_cnt_n;
            par_bit          <= par_n;
            received_data_en <= data_en_n;
            parity_error     <= perr_n;
            frame_error      <= ferr_n;
            if (data_en_n) last_data_received <= shreg;
        end
    end
endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Bench for ps2_byte_receiver: directed PS/2 frames, a frame-level outcome
// model (queue of expected pulses) and a per-cycle compare process.
// Bit timing and timeout are compressed to keep the run short.
module tb_ps2_byte_receiver;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 600;
    localparam int HALF           = 20;
    localparam int MAX_LAT        = 2 + FILTER_LEN + 3;

    typedef struct packed {
        logic [2:0] pulses;   // {data_en, parity_error, frame_error}
        logic [7:0] data;
        logic       stall;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] last_data_received;
    logic       received_data_en, parity_error, frame_error;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    int         en_cnt = 0;
    int         lat;
    int         en_before;
    exp_t       exp_q[$];
    exp_t       e;
    exp_t       p;
    logic [7:0] model_last = 8'h00;
    logic       checking = 1'b0;
    logic       prev_pulse = 1'b0;
    logic [1:0] np;

    ps2_byte_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .last_data_received(last_data_received), .received_data_en(received_data_en),
        .parity_error(parity_error), .frame_error(frame_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame outcome from the protocol rules alone.
    function automatic exp_t predict(input logic [10:0] f, input int n);
        exp_t r;
        r.data  = 8'h00;
        r.stall = 1'b0;
        if (n < 11) begin
            r.pulses = 3'b001;
            r.stall  = 1'b1;
        end else if (!f[10]) begin
            r.pulses = 3'b001;
        end else if (^f[9:1]) begin
            r.pulses = 3'b100;
            r.data   = f[8:1];
        end else begin
            r.pulses = 3'b010;
        end
        return r;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_ok, input logic stop);
        logic par;
        par = par_ok ? ~^d : ^d;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_raw(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ps2_dat = f[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] f, input int n);
        exp_q.push_back(predict(f, n));
        send_raw(f, n);
    endtask

    task automatic wait_outcome(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("outcome_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Per-cycle comparison of the DUT against the expected-outcome queue.
    always @(negedge clock) begin
        if (checking && resetn) begin
            np = {1'b0, received_data_en} + {1'b0, parity_error} + {1'b0, frame_error};
            if (np != 2'd0) begin
                check("one_pulse_kind", 32'(np), 32'd1);
                check("pulse_width", 32'(prev_pulse), 32'd0);
                if (received_data_en) en_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: en=%b perr=%b ferr=%b, expected none",
                             received_data_en, parity_error, frame_error);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'({received_data_en, parity_error, frame_error}), 32'(e.pulses));
                    lat = cyc - last_fall_cyc;
                    if (e.stall)
                        check("timeout_latency", 32'(lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + MAX_LAT), 32'd1);
                    else
                        check("pulse_latency", 32'(lat <= MAX_LAT), 32'd1);
                    if (e.pulses == 3'b100) model_last = e.data;
                end
            end
            check("held_data", 32'(last_data_received), 32'(model_last));
            prev_pulse = (np != 2'd0);
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        // Reset state
        repeat (5) @(negedge clock);
        check("rst_data", 32'(last_data_received), 32'h00);
        check("rst_en", 32'(received_data_en), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        resetn = 1'b1;
        checking = 1'b1;

        // Pin the model against hand-computed frames
        check("frame_1c", 32'(make_frame(8'h1C, 1'b1, 1'b1)), 32'h438);
        p = predict(11'h438, 11);
        check("model_good", 32'(p), 32'({3'b100, 8'h1C, 1'b0}));
        p = predict(11'h638, 11);
        check("model_parity", 32'(p), 32'({3'b010, 8'h00, 1'b0}));

        // Single good frame, then hold
        send_frame(make_frame(8'h1C, 1'b1, 1'b1), 11);
        wait_outcome(100);
        check("data_1c", 32'(last_data_received), 32'h1C);
        repeat (60) @(negedge clock);
        check("hold_1c", 32'(last_data_received), 32'h1C);

        // Back-to-back F0, 1C
        en_before = en_cnt;
        send_frame(make_frame(8'hF0, 1'b1, 1'b1), 11);
        send_frame(make_frame(8'h1C, 1'b1, 1'b1), 11);
        wait_outcome(100);
        check("b2b_count", 32'(en_cnt - en_before), 32'd2);
        check("b2b_last", 32'(last_data_received), 32'h1C);

        // Bad parity
        en_before = en_cnt;
        send_frame(make_frame(8'h1C, 1'b0, 1'b1), 11);
        wait_outcome(100);
        check("perr_no_en", 32'(en_cnt - en_before), 32'd0);
        check("perr_keep", 32'(last_data_received), 32'h1C);

        // Bad stop, then recovery
        send_frame(make_frame(8'h1E, 1'b1, 1'b0), 11);
        wait_outcome(100);
        check("stop_keep", 32'(last_data_received), 32'h1C);
        send_frame(make_frame(8'h16, 1'b1, 1'b1), 11);
        wait_outcome(100);
        check("data_16", 32'(last_data_received), 32'h16);

        // Stalled frame: start + 3 data bits
        send_frame(make_frame(8'h1E, 1'b1, 1'b1), 4);
        wait_outcome(TIMEOUT_CYCLES + 100);
        send_frame(make_frame(8'h1E, 1'b1, 1'b1), 11);
        wait_outcome(100);
        check("data_1e", 32'(last_data_received), 32'h1E);

        // Short glitch while idle
        en_before = en_cnt;
        @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (60) @(negedge clock);
        check("glitch_no_en", 32'(en_cnt - en_before), 32'd0);
        check("glitch_keep", 32'(last_data_received), 32'h1E);

        // Reset mid-frame after 5 bits
        send_raw(make_frame(8'h26, 1'b1, 1'b1), 5);
        @(negedge clock);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst_data", 32'(last_data_received), 32'h00);
        check("midrst_en", 32'(received_data_en), 32'd0);
        check("midrst_ferr", 32'(frame_error), 32'd0);
        model_last = 8'h00;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        send_frame(make_frame(8'h26, 1'b1, 1'b1), 11);
        wait_outcome(100);
        check("data_26", 32'(last_data_received), 32'h26);

        // Quiet tail: nothing further may appear
        repeat (TIMEOUT_CYCLES + 50) @(negedge clock);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_byte_receiver.md
Name: ps2_byte_receiver

Overview:
Upstream stage of the keyboard path. Deserializes the raw PS/2 keyboard clock/data pair into bytes. Each good byte is presented as last_data_received together with a one-cycle received_data_en strobe, which the kit selector and keyboard_control instances consume. Frames with bad start, parity or stop bits are dropped, as are stalled frames. No byte is produced for a dropped frame.

Parameters:
FILTER_LEN, 8, consecutive system-clock cycles a synchronized ps2_clk level must hold before the filtered clock adopts it
TIMEOUT_CYCLES, 100000, cycles allowed between filtered ps2_clk falling edges inside a frame (2 ms at 50 MHz)

Ports:
clock  input  1  system clock (50 MHz)
resetn  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous to clock
ps2_dat  input  1  raw PS/2 data from the keyboard; asynchronous to clock
last_data_received  output  8  most recent good byte; held until the next good byte
received_data_en  output  1  one-cycle pulse when last_data_received updates
parity_error  output  1  one-cycle pulse when a frame is dropped for bad parity
frame_error  output  1  one-cycle pulse when a frame is dropped for bad stop bit or timeout

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (resetn). While resetn=0, all state clears:
  - last_data_received=8'h00; received_data_en, parity_error and frame_error = 0
  - FSM in S_IDLE; sync and filter flops set to 1 (bus idle); shift register and counters cleared
  - Reset mid-frame discards the partial frame; no pulse is generated.
- Synchronization: ps2_clk and ps2_dat each pass through 2 flops.
- Clock filter: the filtered clock changes only after the synced ps2_clk has held its new level for FILTER_LEN consecutive cycles. Shorter glitches are ignored.
- Edge detect: a fall is the filtered clock going 1->0; this produces fall_tick for one cycle. The synced ps2_dat is sampled in the fall_tick cycle.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
- FSM states and transitions:
  - S_IDLE: on fall_tick with data=0, go to S_DATA with bit_cnt=0. Data=1 on fall_tick is ignored (stay in S_IDLE).
  - S_DATA: on each fall_tick, shift the sampled bit into shreg[7] (right shift) and increment bit_cnt. After the 8th bit, go to S_PARITY.
  - S_PARITY: on fall_tick, store the parity bit and go to S_STOP.
  - S_STOP: on fall_tick, check parity and stop, then return to S_IDLE.
    - Parity is good when XOR(shreg, parity_bit)=1.
    - Good parity and stop=1: last_data_received<=shreg and received_data_en=1 in the next cycle.
    - Stop=0: frame_error pulse. This takes priority over the parity check.
    - Stop=1 and bad parity: parity_error pulse.
- Output pulses: exactly one cycle wide, registered, issued the cycle after the stop-bit fall_tick. At most one of received_data_en / parity_error / frame_error is set per frame.
- Latency: from a raw ps2_clk stop-bit falling edge to the output pulse is at most 2+FILTER_LEN+3 cycles, and constant for a given clean edge.
- Timeout:
  - The counter clears on every fall_tick and on entry to S_IDLE, and increments in any state other than S_IDLE.
  - When it reaches TIMEOUT_CYCLES-1 without a fall_tick: pulse frame_error, go to S_IDLE and discard the partial byte.
  - The counter saturates and never wraps.
  - If timeout and fall_tick occur in the same cycle, the fall_tick wins (the counter clears).
- Back-to-back frames: a new start bit is accepted on the very next fall_tick after the stop bit.
- last_data_received never changes except on a received_data_en cycle.
- Host-to-device transmission is not supported; ps2_clk and ps2_dat are inputs only.

Test Plan:
- Frame 0x1C with parity=0 and stop=1, 80 us bit period → one received_data_en pulse, last_data_received=8'h1C, no error pulses; the value holds after the pulse.
- Frames F0 then 1C back-to-back → two received_data_en pulses, with data F0 then 1C in order.
- Frame 0x1C with parity=1 → parity_error single pulse; received_data_en stays 0; last_data_received keeps its prior value.
- Frame 0x1E with stop=0 → frame_error pulse only. Then send a valid 0x16 → received_data_en pulse with data=8'h16.
- Start bit plus 3 data bits, then ps2_clk held high → frame_error pulse TIMEOUT_CYCLES cycles after the last fall; the next valid 0x1E is received correctly.
- A 3-cycle low glitch on ps2_clk while idle → no state change, no pulses. Separately, assert resetn=0 mid-frame after 5 bits → outputs zero; the next full frame 0x26 is received as 8'h26.
